// File: rtl/lane_serializer.sv
// Buffers 4-lane words in a small FIFO and emits their lanes one byte per clock.
// Build option: define SKIP_INVALID_EN to skip invalid lanes instead of emitting 00/v0 slots.
module lane_serializer #(
  parameter int BUF_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [7:0] data_0rf,
  input  logic [7:0] data_1rf,
  input  logic [7:0] data_2rf,
  input  logic [7:0] data_3rf,
  input  logic       valid_0rf,
  input  logic       valid_1rf,
  input  logic       valid_2rf,
  input  logic       valid_3rf,
  output logic       in_ready,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       busy,
  output logic       overflow
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          valid_out_q, valid_out_d;
  logic          overflow_q, overflow_d;

  logic [7:0]    lane_data [4];
  logic [3:0]    lane_valid;
  logic          offer, capture, pop;

  logic [7:0]    mem_data_q [BUF_DEPTH][4];
  logic [3:0]    mem_mask_q [BUF_DEPTH];
  logic [3:0]    head_mask;
  logic [1:0]    lane_sel;
  logic          last_lane;
  logic [7:0]    emit_byte;
  logic          emit_valid;

  assign lane_data[0] = data_0rf;
  assign lane_data[1] = data_1rf;
  assign lane_data[2] = data_2rf;
  assign lane_data[3] = data_3rf;
  assign lane_valid   = {valid_3rf, valid_2rf, valid_1rf, valid_0rf};

  assign offer     = |lane_valid;
  assign in_ready  = (count_q < DEPTH_C);
  assign capture   = offer && in_ready;
  assign busy      = (count_q != '0);
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign overflow  = overflow_q;
  assign head_mask = mem_mask_q[rd_ptr_q];

  // Buffer contents need no reset; only count/pointers define occupancy.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mem
    always_ff @(posedge clk) begin
      if (capture) mem_data_q[wr_ptr_q][gi] <= lane_data[gi];
    end
  end

  always_ff @(posedge clk) begin
    if (capture) mem_mask_q[wr_ptr_q] <= lane_valid;
  end

`ifdef SKIP_INVALID_EN
  logic [3:0] done_q, done_d;
  logic [3:0] rem_mask;

  assign rem_mask = head_mask & ~done_q;

  always_comb begin
    lane_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rem_mask[i]) lane_sel = 2'(i);
    end
  end

  assign last_lane  = ((rem_mask & ~(4'b0001 << lane_sel)) == 4'b0000);
  assign emit_byte  = mem_data_q[rd_ptr_q][lane_sel];
  assign emit_valid = 1'b1;
`else
  logic [1:0] lane_q, lane_d;

  assign lane_sel   = lane_q;
  assign last_lane  = (lane_q == 2'd3);
  assign emit_byte  = head_mask[lane_q] ? mem_data_q[rd_ptr_q][lane_q] : 8'h00;
  assign emit_valid = head_mask[lane_q];
`endif

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= 8'h00;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef SKIP_INVALID_EN
      done_q      <= 4'b0000;
`else
      lane_q      <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
`ifdef SKIP_INVALID_EN
      done_q      <= done_d;
`else
      lane_q      <= lane_d;
`endif
    end
  end

  // Stay in SEND across a pop whenever another word remains or arrives.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = SEND;
      SEND:    if (pop && !capture && (count_q == CW'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_out_d  = 8'h00;
    valid_out_d = 1'b0;
    pop         = 1'b0;
`ifdef SKIP_INVALID_EN
    done_d      = done_q;
`else
    lane_d      = lane_q;
`endif
    if (state_q == SEND) begin
      data_out_d  = emit_byte;
      valid_out_d = emit_valid;
      pop         = last_lane;
`ifdef SKIP_INVALID_EN
      done_d      = last_lane ? 4'b0000 : (done_q | (4'b0001 << lane_sel));
`else
      lane_d      = lane_q + 2'd1;
`endif
    end

    overflow_d = overflow_q | (offer & ~in_ready);
    wr_ptr_d   = capture ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({capture, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

endmodule

// File: tb/tb_lane_serializer.sv
// Randomized and directed bench for lane_serializer against a queue-based output model.
module tb_lane_serializer;
  localparam int DEPTH = 2;

  logic       clk, reset_L;
  logic [7:0] d0, d1, d2, d3;
  logic       v0, v1, v2, v3;
  logic       in_ready, valid_out, busy, overflow;
  logic [7:0] data_out;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic       last;
  } pair_t;

  pair_t pq[$];
  int    wcnt  = 0;
  logic  ovf_m = 1'b0;

  lane_serializer #(.BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_L(reset_L),
    .data_0rf(d0), .data_1rf(d1), .data_2rf(d2), .data_3rf(d3),
    .valid_0rf(v0), .valid_1rf(v1), .valid_2rf(v2), .valid_3rf(v3),
    .in_ready(in_ready), .data_out(data_out), .valid_out(valid_out),
    .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] bytes, input logic [3:0] m);
    {d3, d2, d1, d0} = bytes;
    {v3, v2, v1, v0} = m;
  endtask

  task automatic model_clear();
    pq.delete();
    wcnt  = 0;
    ovf_m = 1'b0;
  endtask

  // Expand an accepted word into the output slots it must produce.
  task automatic model_capture(input logic [31:0] bytes, input logic [3:0] m);
    pair_t p;
    int    last_i;
    last_i = 0;
`ifdef SKIP_INVALID_EN
    for (int i = 0; i < 4; i++) if (m[i]) last_i = i;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        p.d = bytes[8*i +: 8];
        p.v = 1'b1;
        p.last = (i == last_i);
        pq.push_back(p);
      end
    end
`else
    for (int i = 0; i < 4; i++) begin
      p.d = m[i] ? bytes[8*i +: 8] : 8'h00;
      p.v = m[i];
      p.last = (i == 3);
      pq.push_back(p);
    end
`endif
    wcnt++;
  endtask

  task automatic cycle(input string tag);
    pair_t       e;
    logic [31:0] bytes;
    logic [3:0]  m;
    logic        rdy;
    @(negedge clk);
    rdy = (wcnt < DEPTH);
    chk({tag, ":in_ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, ":busy"}, 32'(busy), 32'(wcnt != 0));
    bytes = {d3, d2, d1, d0};
    m     = {v3, v2, v1, v0};
    e     = '0;
    if (pq.size() > 0) begin
      e = pq.pop_front();
      if (e.last) wcnt--;
    end
    if (|m) begin
      if (rdy) model_capture(bytes, m);
      else     ovf_m = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, ":data_out"}, 32'(data_out), 32'(e.d));
    chk({tag, ":valid_out"}, 32'(valid_out), 32'(e.v));
    chk({tag, ":overflow"}, 32'(overflow), 32'(ovf_m));
    $display("cycle %s: data_out=%02h valid_out=%0b in_ready=%0b busy=%0b overflow=%0b",
             tag, data_out, valid_out, in_ready, busy, overflow);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, ":data_out"}, 32'(data_out), 32'h00);
    chk({tag, ":valid_out"}, 32'(valid_out), 32'h0);
    chk({tag, ":in_ready"}, 32'(in_ready), 32'h1);
    chk({tag, ":busy"}, 32'(busy), 32'h0);
    chk({tag, ":overflow"}, 32'(overflow), 32'h0);
  endtask

  // Called #1 after a rising edge; asserts reset between edges.
  task automatic apply_reset(input string tag);
    #2 reset_L = 1'b0;
    #1 reset_check({tag, "_now"});
    @(posedge clk);
    #1 reset_check({tag, "_held"});
    @(negedge clk);
    reset_L = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, budget;
    logic [3:0] m;

    reset_L = 1'b0;
    drive(32'h44332211, 4'hF);
    repeat (2) @(posedge clk);
    #1 reset_check("rst_hold");
    @(negedge clk);
    drive(32'h0, 4'h0);
    reset_L = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    repeat (3) cycle("post_rst");

    drive(32'h44332211, 4'hF);
    cycle("full");
    drive(32'h0, 4'h0);
    repeat (6) cycle("full");

    drive(32'hDDCCBBAA, 4'b1010);
    cycle("sparse");
    drive(32'h0, 4'h0);
    repeat (6) cycle("sparse");

    for (int i = 0; i < 3; i++) begin
      drive($urandom, 4'hF);
      cycle("b2b");
    end
    drive(32'h0, 4'h0);
    repeat (10) cycle("b2b_drain");
    apply_reset("rst_ovf");

    k = 0;
    budget = 0;
    while (k < 6 && budget < 200) begin
      if (in_ready) begin
        drive($urandom, 4'hF);
        k++;
      end else begin
        drive(32'h0, 4'h0);
      end
      cycle("wrap");
      budget++;
    end
    chk("wrap_words", 32'(k), 32'd6);
    drive(32'h0, 4'h0);
    repeat (30) cycle("wrap_drain");

    drive(32'h0D0C0B0A, 4'hF);
    cycle("mid");
    drive(32'h0, 4'h0);
    cycle("mid");
    cycle("mid");
    apply_reset("rst_mid");
    repeat (6) cycle("after_mid");

    for (int i = 0; i < 400; i++) begin
      m = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) m = 4'h0;
      drive($urandom, m);
      cycle("rnd");
    end
    drive(32'h0, 4'h0);
    repeat (20) cycle("rnd_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lane_serializer.md
# lane_serializer

Downstream neighbour of the recirculation demux. Takes the 4-lane "to flops" word (data_0rf..data_3rf, valid_0rf..valid_3rf), buffers whole words in a small FIFO and emits the valid lanes one byte per clock on a single 8-bit output with its own valid. It gives the upstream stage backpressure (in_ready) and flags any word lost while the buffer is full.

## Interface

Parameters:
- BUF_DEPTH, default 2: number of 4-lane words buffered; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_L  input  1  reset, asynchronous and active-low.
- data_0rf, data_1rf, data_2rf, data_3rf  input  8 each  lane data from the recirculation demux.
- valid_0rf, valid_1rf, valid_2rf, valid_3rf  input  1 each  lane valids.
- in_ready  output  1  high when the buffer can accept a word this cycle.
- data_out  output  8  serialized byte, registered.
- valid_out  output  1  data_out qualifier, registered.
- busy  output  1  high while any word is buffered or being emitted.
- overflow  output  1  sticky flag: a word was offered while in_ready=0.

## Operation

- A word is offered when valid_any = OR of the four valid_Nrf inputs. A word with valid_any=0 is ignored and never stored.
- Capture: offered and in_ready=1 at a rising edge. Store the 4 bytes plus a 4-bit mask of the lane valids at the write pointer, and increment count.
- in_ready = (count < BUF_DEPTH). It comes from registered count only. A pop in the same cycle does not raise it.
- Drop: offered and in_ready=0 at an edge. The word is discarded, overflow is set to 1 and stays 1 until reset.
- FSM, two states:
  - IDLE: count=0. valid_out=0, data_out=8'h00. Go to SEND on the edge after a capture.
  - SEND: each cycle, emit the lowest-numbered lane still set in the head word's remaining mask into data_out/valid_out=1, then clear that bit.
  - When the last remaining bit is emitted, pop the head word (rd pointer+1, count-1).
  - If another word is buffered, the next cycle starts on it with no bubble. Otherwise return to IDLE.
- Simultaneous capture and pop in one cycle: count is unchanged and both pointers advance.
- Pointers are log2(BUF_DEPTH) bits wide and wrap modulo BUF_DEPTH.
- busy = (count != 0).
- Lane order within a word is always 0, 1, 2, 3.

## Timing

- Reset (asynchronous, reset_L=0):
  - data_out=8'h00, valid_out=0, overflow=0.
  - count=0, pointers=0, state=IDLE, so in_ready=1 and busy=0.
  - Buffer contents are don't-care.
- Reset asserted mid-word aborts the word immediately. Remaining lanes are lost and no partial output follows after release.
- Latency: a word captured at edge N has its first lane on data_out after edge N+1.
- A word with k valid lanes occupies k consecutive output cycles.
- Throughput: one byte per clock while the buffer is non-empty.
- When the buffer is full, in_ready falls in the cycle after the capture that filled it. It rises in the cycle after the pop that freed a slot.

## Configuration

- Macro SKIP_INVALID_EN.
- Defined: invalid lanes are skipped as described in Operation, and a word takes popcount(mask) cycles.
- Undefined: every captured word takes exactly 4 cycles. Lane N drives data_out = (valid_Nrf ? byte : 8'h00) and valid_out = mask bit N. The pop happens after lane 3.
- All other behaviour is identical in both configurations.

## Test plan

- Reset: hold reset_L=0 with a word offered. Required: data_out=00, valid_out=0, in_ready=1, busy=0, overflow=0. After release, nothing is emitted until a new capture.
- Single full word: offer {11,22,33,44}, all valids=1, for one cycle. Required: data_out = 11, 22, 33, 44 on the four cycles after the next edge, valid_out=1 throughout, then valid_out=0 and busy=0.
- Sparse word (SKIP_INVALID_EN defined): offer valids 1010 with data {AA,BB,CC,DD} (lane0..3). Required: output BB, DD in 2 cycles.
- Same sparse word with the macro undefined. Required: output 00/v0, BB/v1, 00/v0, DD/v1.
- Back-to-back and full (BUF_DEPTH=2): offer three full words on consecutive cycles.
  - Required: in_ready=0 in the cycle the third word is offered, so the third word is dropped and overflow=1.
  - Output is 8 contiguous bytes with no bubble between words.
  - overflow stays 1 until reset.
- Pointer wrap: stream 6 full words, each offered only when in_ready=1. Required: 24 bytes in order, overflow=0.
- Mid-word reset: assert reset_L=0 during the 2nd lane of a word. Required: outputs go to 00/0 immediately, no lanes follow after release, and in_ready=1.
